// File: rtl/spi_target_regs.sv
// SPI mode-0 target with a 16x8 register file, oversampled in the clk domain.
// Writes drive the LEDs and a strobe port; the top register reads live status.
module spi_target_regs #(
  parameter int ADDR_W      = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sck,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic [7:0]        status,
  output logic              wr_stb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic [2:0]        led
);

  localparam int NREG = 1 << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sck_dly_q;
  logic                   cs_dly_q;

  logic sck_s, cs_s, mosi_s;
  logic sck_rise, sck_fall;
  logic cs_fall, cs_rise;

  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        rx_next;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] addr_inc, cmd_addr;
  logic              wr_mode_q, wr_mode_d;
  logic              miso_q, miso_d;
  logic              oe_q, oe_d;
  logic              stb_q;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              reg_we;
  logic [7:0]        rd_cmd, rd_next;
  logic [7:0]        regs_q [NREG];

  // cs sync resets to "selected" so a frame in progress at reset
  // release is ignored until cs_n is seen high and then low again.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sck_sync_q  <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sck_dly_q   <= 1'b0;
      cs_dly_q    <= 1'b0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sck_dly_q   <= sck_s;
      cs_dly_q    <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_dly_q;
  assign sck_fall = ~sck_s & sck_dly_q;
  assign cs_fall  = ~cs_s & cs_dly_q;
  assign cs_rise  = cs_s & ~cs_dly_q;

  assign rx_next  = {rx_q, mosi_s};
  assign cmd_addr = rx_next[ADDR_W-1:0];
  assign addr_inc = addr_q + ADDR_W'(1);

  assign rd_cmd  = (cmd_addr == '1) ? status : regs_q[cmd_addr];
  assign rd_next = (addr_inc == '1) ? status : regs_q[addr_inc];

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    tx_d      = tx_q;
    addr_d    = addr_q;
    wr_mode_d = wr_mode_q;
    miso_d    = miso_q;
    oe_d      = oe_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    reg_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_rise) begin
          oe_d = 1'b0;
        end else if (cs_fall) begin
          state_d   = CMD;
          bit_cnt_d = '0;
          tx_d      = '0;
          miso_d    = 1'b0;
          oe_d      = 1'b1;
        end
      end
      CMD, DATA: begin
        if (cs_rise) begin
          state_d = IDLE;
          oe_d    = 1'b0;
        end else if (sck_rise) begin
          rx_d      = rx_next[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (state_q == CMD) begin
              state_d   = DATA;
              wr_mode_d = rx_next[7];
              addr_d    = cmd_addr;
              tx_d      = rd_cmd;
            end else begin
              if (wr_mode_q && (addr_q != '1)) begin
                reg_we    = 1'b1;
                wr_addr_d = addr_q;
                wr_data_d = rx_next;
              end
              addr_d = addr_inc;
              tx_d   = rd_next;
            end
          end
        end else if (sck_fall) begin
          miso_d = tx_q[7];
          tx_d   = {tx_q[6:0], 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      rx_q      <= '0;
      tx_q      <= '0;
      addr_q    <= '0;
      wr_mode_q <= 1'b0;
      miso_q    <= 1'b0;
      oe_q      <= 1'b0;
      stb_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      tx_q      <= tx_d;
      addr_q    <= addr_d;
      wr_mode_q <= wr_mode_d;
      miso_q    <= miso_d;
      oe_q      <= oe_d;
      stb_q     <= reg_we;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else if (reg_we) begin
      regs_q[addr_q] <= rx_next;
    end
  end

  assign miso    = miso_q;
  assign miso_oe = oe_q;
  assign wr_stb  = stb_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign led     = regs_q[0][2:0];

endmodule

// File: tb/tb_spi_target_regs.sv
// Bench for spi_target_regs: directed frames plus random frames
// checked against a byte-level register-file model.
module tb_spi_target_regs;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sck = 1'b0;
  logic       cs_n = 1'b1;
  logic       mosi = 1'b0;
  logic [7:0] status = 8'h00;
  logic       miso, miso_oe, wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] led;

  spi_target_regs #(.ADDR_W(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .sck(sck), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .status(status),
    .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_data(wr_data), .led(led)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  logic [7:0]  mreg [16];
  logic [7:0]  txb[$];
  logic [7:0]  rxb[$];
  logic [7:0]  expm[$];
  logic [11:0] exps[$];
  logic [11:0] obss[$];

  always @(negedge clk)
    if (rst && wr_stb === 1'b1) obss.push_back({wr_addr, wr_data});

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic sbit(input logic b, output logic r);
    mosi = b;
    repeat (4) @(negedge clk);
    r = miso;
    sck = 1'b1;
    repeat (4) @(negedge clk);
    sck = 1'b0;
  endtask

  task automatic sbyte(input logic [7:0] t, output logic [7:0] r);
    logic rb;
    for (int i = 7; i >= 0; i--) begin
      sbit(t[i], rb);
      r[i] = rb;
    end
  endtask

  task automatic frame(input int gap);
    logic [7:0] r;
    rxb.delete();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    chk("oe_on", 32'(miso_oe), 32'd1);
    foreach (txb[i]) begin
      sbyte(txb[i], r);
      rxb.push_back(r);
    end
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (gap) @(negedge clk);
    chk("oe_off", 32'(miso_oe), 32'd0);
  endtask

  // Byte-level model: command byte, then auto-incrementing accesses.
  task automatic model();
    logic [3:0] a;
    logic       w;
    expm.delete();
    exps.delete();
    w = txb[0][7];
    a = txb[0][3:0];
    expm.push_back(8'h00);
    for (int k = 1; k < txb.size(); k++) begin
      if (w) begin
        if (a != 4'd15) begin
          mreg[a] = txb[k];
          exps.push_back({a, txb[k]});
        end
      end else begin
        expm.push_back((a == 4'd15) ? status : mreg[a]);
      end
      a = a + 4'd1;
    end
  endtask

  task automatic run(input string tag, input int gap);
    model();
    obss.delete();
    frame(gap);
    chk({tag, "_nstb"}, obss.size(), exps.size());
    foreach (exps[i])
      if (i < obss.size()) chk({tag, "_stb"}, 32'(obss[i]), 32'(exps[i]));
    foreach (expm[i]) chk({tag, "_miso"}, 32'(rxb[i]), 32'(expm[i]));
    chk({tag, "_led"}, 32'(led), 32'(mreg[0][2:0]));
  endtask

  initial begin
    logic [7:0] r;
    logic       rb;
    int         n;
    for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_miso", 32'(miso), 32'd0);
    chk("rst_oe", 32'(miso_oe), 32'd0);
    chk("rst_stb", 32'(wr_stb), 32'd0);
    chk("rst_waddr", 32'(wr_addr), 32'd0);
    chk("rst_wdata", 32'(wr_data), 32'd0);
    chk("rst_led", 32'(led), 32'd0);
    rst = 1'b1;
    repeat (6) @(negedge clk);

    txb = '{8'h80, 8'hA5};
    run("wr0", 4);
    chk("wr0_led5", 32'(led), 32'h5);
    if (obss.size() > 0) chk("wr0_ent", 32'(obss[0]), 32'h0A5);

    txb = '{8'h8E, 8'h11, 8'h22, 8'h33};
    run("burst", 4);
    chk("burst_cnt", obss.size(), 32'd2);
    chk("burst_led", 32'(led), 32'h3);

    status = 8'h3C;
    txb = '{8'h0F, 8'h00, 8'h00};
    run("rd15", 4);
    chk("rd15_b1", 32'(rxb[1]), 32'h3C);
    chk("rd15_b2", 32'(rxb[2]), 32'h33);

    // Partial data byte must be discarded.
    obss.delete();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    sbyte(8'h83, r);
    for (int i = 0; i < 5; i++) sbit(1'b1, rb);
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("part_nstb", obss.size(), 32'd0);
    txb = '{8'h03, 8'h00};
    run("part_rd", 4);
    txb = '{8'h83, 8'h5A};
    run("part_wr", 4);
    txb = '{8'h03, 8'h00};
    run("part_rd2", 4);

    // Reset in the middle of a data byte.
    obss.delete();
    cs_n = 1'b0;
    repeat (4) @(negedge clk);
    sbyte(8'h81, r);
    for (int i = 0; i < 4; i++) sbit(1'b1, rb);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("mrst_miso", 32'(miso), 32'd0);
    chk("mrst_oe", 32'(miso_oe), 32'd0);
    chk("mrst_stb", 32'(wr_stb), 32'd0);
    chk("mrst_waddr", 32'(wr_addr), 32'd0);
    chk("mrst_wdata", 32'(wr_data), 32'd0);
    chk("mrst_led", 32'(led), 32'd0);
    for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) sbit(1'b1, rb);
    mosi = 1'b0;
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("mrst_nstb", obss.size(), 32'd0);
    txb = '{8'h81, 8'h7E};
    run("post_wr", 4);
    txb = '{8'h00, 8'h00, 8'h00};
    run("post_rd", 4);
    chk("post_reg1", 32'(rxb[2]), 32'h7E);

    // Random back-to-back frames, minimum cs_n high gap.
    for (int f = 0; f < 30; f++) begin
      status = 8'($urandom);
      txb.delete();
      txb.push_back({1'($urandom_range(0, 1)), 3'($urandom), 4'($urandom)});
      n = $urandom_range(1, 5);
      for (int k = 0; k < n; k++) txb.push_back(8'($urandom));
      run("rnd", 4);
    end

    status = 8'($urandom);
    txb.delete();
    txb.push_back(8'h00);
    for (int k = 0; k < 16; k++) txb.push_back(8'h00);
    run("dump", 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
